// File: rtl/decryption_pkg.sv
// Shared constants, state type and index-step helper for the decryption engines.
// Scytale key checking is enabled by defining SCYTALE_KEY_CHECK_EN.
package decryption_pkg;

  localparam int D_WIDTH       = 8;
  localparam int KEY_WIDTH     = 8;
  localparam int MAX_NOF_CHARS = 50;
  localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

  localparam int IDX_W  = $clog2(MAX_NOF_CHARS) + 1;
  localparam int ADDR_W = $clog2(MAX_NOF_CHARS);
  localparam int SUM_W  = ((IDX_W > KEY_WIDTH) ? IDX_W : KEY_WIDTH) + 1;

  typedef enum logic {COLLECT, EMIT} scy_state_t;

  // Column-wise read order. A zero column count behaves as one, and a column
  // count at or above the message length collapses to the length, which
  // yields the bytes in their original order.
  function automatic logic [IDX_W-1:0] scy_next_idx(
    input logic [IDX_W-1:0]     j,
    input logic [KEY_WIDTH-1:0] m,
    input logic [IDX_W-1:0]     len
  );
    logic [SUM_W-1:0] len_w;
    logic [SUM_W-1:0] step;
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] res;
    len_w = SUM_W'(len);
    step  = (m == '0) ? SUM_W'(1) : SUM_W'(m);
    if (step > len_w) begin
      step = len_w;
    end
    sum = SUM_W'(j) + step;
    if (sum < len_w) begin
      res = IDX_W'(sum);
    end else begin
      res = IDX_W'(sum - len_w + SUM_W'(1));
    end
    return res;
  endfunction

endpackage

// File: rtl/scytale_char_buffer.sv
// Character store for the scytale engine: synchronous write, combinational read.
// The write pointer lives in the parent.
module scytale_char_buffer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 50,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/scytale_decryption.sv
// Scytale decryption engine: buffers ciphertext until the terminator, then emits it column-wise.
// Define SCYTALE_KEY_CHECK_EN to reject messages whose length does not match N*M (adds err_o).
module scytale_decryption
  import decryption_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
`ifdef SCYTALE_KEY_CHECK_EN
  ,
  output logic                 err_o
`endif
);

  scy_state_t state_reg, state_next;
  logic [IDX_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     len_reg, len_next;
  logic [IDX_W-1:0]     j_reg, j_next;
  logic [IDX_W-1:0]     k_reg, k_next;
  logic [KEY_WIDTH-1:0] m_reg, m_next;
  logic [D_WIDTH-1:0]   data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 busy_reg, busy_next;

  logic                 we;
  logic [ADDR_W-1:0]    raddr;
  logic [D_WIDTH-1:0]   rdata;
  logic                 start_ok;

`ifdef SCYTALE_KEY_CHECK_EN
  logic                     ovf_reg, ovf_next;
  logic                     err_reg, err_next;
  logic [KEY_WIDTH-1:0]     m_in_eff;
  logic [2*KEY_WIDTH-1:0]   key_prod;

  assign m_in_eff = (key_M == '0) ? KEY_WIDTH'(1) : key_M;
  assign key_prod = (2*KEY_WIDTH)'(key_N) * (2*KEY_WIDTH)'(m_in_eff);
  assign start_ok = !ovf_reg && ((2*KEY_WIDTH)'(cnt_reg) == key_prod);
  assign err_o    = err_reg;
`else
  assign start_ok = 1'b1;
`endif

  // While collecting, the only read needed is byte 0 for the token cycle.
  assign raddr = (state_reg == EMIT) ? j_reg[ADDR_W-1:0] : '0;

  scytale_char_buffer #(
    .WIDTH (D_WIDTH),
    .DEPTH (MAX_NOF_CHARS),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk  (clk),
    .we   (we),
    .waddr(cnt_reg[ADDR_W-1:0]),
    .wdata(data_i),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    m_next     = m_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    busy_next  = 1'b0;
    we         = 1'b0;
`ifdef SCYTALE_KEY_CHECK_EN
    ovf_next   = ovf_reg;
    err_next   = 1'b0;
`endif
    case (state_reg)
      COLLECT: begin
        if (valid_i) begin
          if (data_i != START_DECRYPTION_TOKEN) begin
            if (cnt_reg < IDX_W'(MAX_NOF_CHARS)) begin
              we       = 1'b1;
              cnt_next = cnt_reg + IDX_W'(1);
            end
`ifdef SCYTALE_KEY_CHECK_EN
            else begin
              ovf_next = 1'b1;
            end
`endif
          end else begin
            len_next = cnt_reg;
            m_next   = key_M;
            k_next   = IDX_W'(1);
`ifdef SCYTALE_KEY_CHECK_EN
            ovf_next = 1'b0;
`endif
            if (!start_ok) begin
              cnt_next = '0;
`ifdef SCYTALE_KEY_CHECK_EN
              err_next = 1'b1;
`endif
            end else if (cnt_reg != '0) begin
              // Byte 0 leaves on the token edge so output starts next cycle.
              state_next = EMIT;
              data_next  = rdata;
              valid_next = 1'b1;
              busy_next  = 1'b1;
              j_next     = scy_next_idx('0, key_M, cnt_reg);
            end
          end
        end
      end
      EMIT: begin
        if (k_reg == len_reg) begin
          state_next = COLLECT;
          cnt_next   = '0;
        end else begin
          data_next  = rdata;
          valid_next = 1'b1;
          busy_next  = 1'b1;
          k_next     = k_reg + IDX_W'(1);
          j_next     = scy_next_idx(j_reg, m_reg, len_reg);
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COLLECT;
      cnt_reg   <= '0;
      len_reg   <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      m_reg     <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
`ifdef SCYTALE_KEY_CHECK_EN
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      m_reg     <= m_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
`ifdef SCYTALE_KEY_CHECK_EN
      ovf_reg   <= ovf_next;
      err_reg   <= err_next;
`endif
    end
  end

  assign busy    = busy_reg;
  assign data_o  = data_reg;
  assign valid_o = valid_reg;

endmodule

// File: tb/tb_scytale_decryption.sv
// Bench for scytale_decryption: a message-level model checked every cycle plus literal plaintexts.
// Honours SCYTALE_KEY_CHECK_EN the same way the design does.
module tb_scytale_decryption;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic [7:0] key_N = 8'hFF;
  logic [7:0] key_M = 8'hFF;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;
`ifdef SCYTALE_KEY_CHECK_EN
  logic       err_o;
`endif

  int checks = 0;
  int failures = 0;

  scytale_decryption dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .key_N  (key_N),
    .key_M  (key_M),
    .busy   (busy),
    .data_o (data_o),
    .valid_o(valid_o)
`ifdef SCYTALE_KEY_CHECK_EN
    ,
    .err_o  (err_o)
`endif
  );

  always #5 clk = ~clk;

  // Message model: collect bytes, then at the token lay them out in rows of M
  // and read down the columns.
  logic [7:0] msg[$];
  logic [7:0] pend[$];
  logic [7:0] got[$];
  logic       active = 1'b0;
  logic       ovf = 1'b0;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_err = 1'b0;
  int         mdl_len;
  int         mdl_m;
  logic       mdl_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg.delete();
      pend.delete();
      active    = 1'b0;
      ovf       = 1'b0;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_err   = 1'b0;
    end else begin
      exp_err = 1'b0;
      if (active) begin
        if (pend.size() > 0) begin
          exp_data  = pend.pop_front();
          exp_valid = 1'b1;
        end else begin
          exp_valid = 1'b0;
          active    = 1'b0;
        end
      end else begin
        exp_valid = 1'b0;
        if (valid_i) begin
          if (data_i != 8'hFA) begin
            if (msg.size() < 50) msg.push_back(data_i);
            else ovf = 1'b1;
          end else begin
            mdl_len = msg.size();
            mdl_m   = (key_M == 0) ? 1 : int'(key_M);
            mdl_ok  = 1'b1;
`ifdef SCYTALE_KEY_CHECK_EN
            if (ovf || mdl_len != int'(key_N) * mdl_m) begin
              mdl_ok  = 1'b0;
              exp_err = 1'b1;
            end
`endif
            if (mdl_ok && mdl_len > 0) begin
              if (mdl_m > mdl_len) mdl_m = mdl_len;
              for (int c = 0; c < mdl_m; c++)
                for (int idx = c; idx < mdl_len; idx += mdl_m)
                  pend.push_back(msg[idx]);
              exp_data  = pend.pop_front();
              exp_valid = 1'b1;
              active    = 1'b1;
            end
            msg.delete();
            ovf = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (valid_o !== exp_valid || busy !== exp_valid || data_o !== exp_data
`ifdef SCYTALE_KEY_CHECK_EN
        || err_o !== exp_err
`endif
       ) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t actual valid_o=%b busy=%b data_o=%h required valid_o=%b busy=%b data_o=%h",
               $time, valid_o, busy, data_o, exp_valid, exp_valid, exp_data);
    end
    if (valid_o) got.push_back(data_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_msg(input string name, input string s);
    string gs = "";
    logic  bad = 1'b0;
    checks++;
    if (got.size() != s.len()) bad = 1'b1;
    for (int i = 0; i < got.size(); i++) begin
      gs = {gs, string'(got[i])};
      if (i < s.len() && got[i] != s[i]) bad = 1'b1;
    end
    if (bad) begin
      failures++;
      $display("FAIL %s actual=\"%s\" required=\"%s\"", name, gs, s);
    end else begin
      $display("msg %s plaintext=\"%s\"", name, gs);
    end
  endtask

  task automatic send(input logic [7:0] b);
    valid_i = 1'b1;
    data_i  = b;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
    send(8'hFA);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual busy=1 required busy=0", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid_o", 32'(valid_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data_o", 32'(data_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    key_N = 8'd2; key_M = 8'd3; got.delete();
    send_str("ABCDEF");
    wait_idle("n2m3");
    expect_msg("n2m3", "ADBECF");

    key_N = 8'd3; key_M = 8'd2; got.delete();
    send_str("ABCDEF");
    wait_idle("n3m2");
    expect_msg("n3m2", "ACEBDF");
    key_N = 8'd1; key_M = 8'd2; got.delete();
    send_str("XY");
    wait_idle("back2back");
    expect_msg("back2back", "XY");

    got.delete();
    send(8'hFA);
    repeat (4) @(negedge clk);
    expect_msg("empty_token", "");

    key_N = 8'd2; key_M = 8'd3; got.delete();
    send_str("ABCDEF");
    key_M = 8'd2;
    send("Z"); send("Z"); send("Z");
    key_M = 8'd7;
    wait_idle("keychg");
    expect_msg("keychg", "ADBECF");
    key_N = 8'd1; key_M = 8'd2; got.delete();
    send_str("GH");
    wait_idle("after_drop");
    expect_msg("after_drop", "GH");

    key_N = 8'd2; key_M = 8'd3;
    send_str("ABCDEF");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid_o", 32'(valid_o), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_data_o", 32'(data_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got.delete();
    send_str("ABCDEF");
    wait_idle("post_rst");
    expect_msg("post_rst", "ADBECF");

`ifdef SCYTALE_KEY_CHECK_EN
    key_N = 8'd2; key_M = 8'd3; got.delete();
    send_str("ABCDE");
    chk("err_len_pulse", 32'(err_o), 1);
    @(negedge clk);
    chk("err_len_clear", 32'(err_o), 0);
    repeat (3) @(negedge clk);
    expect_msg("err_len_noout", "");

    key_N = 8'd5; key_M = 8'd10; got.delete();
    for (int i = 1; i <= 52; i++) send(8'(i));
    send(8'hFA);
    chk("err_ovf_pulse", 32'(err_o), 1);
    @(negedge clk);
    chk("err_ovf_clear", 32'(err_o), 0);
    repeat (3) @(negedge clk);
    expect_msg("err_ovf_noout", "");

    key_N = 8'd2; key_M = 8'd3; got.delete();
    send_str("ABCDEF");
    wait_idle("recover");
    expect_msg("recover", "ADBECF");
`else
    key_N = 8'hFF; key_M = 8'hFF; got.delete();
    send_str("ABC");
    wait_idle("reset_key");
    expect_msg("reset_key", "ABC");

    key_N = 8'd6; key_M = 8'd0; got.delete();
    send_str("ABCDEF");
    wait_idle("m_zero");
    expect_msg("m_zero", "ABCDEF");

    key_N = 8'hFF; key_M = 8'hFF; got.delete();
    for (int i = 1; i <= 52; i++) send(8'(i));
    send(8'hFA);
    wait_idle("overflow");
    begin
      logic bad = 1'b0;
      if (got.size() != 50) bad = 1'b1;
      for (int i = 0; i < got.size(); i++)
        if (got[i] != 8'(i + 1)) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL overflow actual_len=%0d required_len=50 in order 01..32", got.size());
      end else begin
        $display("msg overflow plaintext_len=%0d", got.size());
      end
    end
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scytale_decryption.md
# scytale_decryption

Scytale decryption engine, fed by the decryption register file's `scytale_key` output. It buffers an incoming ciphertext byte stream until the terminator character arrives. It then emits the plaintext one byte per cycle by reading the buffer column-wise. It sits beside the Caesar and zigzag engines, behind the select-driven input demux.

## Interface
- `D_WIDTH`, 8: character width in bits.
- `KEY_WIDTH`, 8: width of each key half.
- `MAX_NOF_CHARS`, 50: buffer depth in characters.
- `START_DECRYPTION_TOKEN`, 8'hFA: terminator character.
- `clk`  in  1  clock; single clock domain, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_i`  in  D_WIDTH  ciphertext character.
- `valid_i`  in  1  `data_i` is valid this cycle.
- `key_N`  in  KEY_WIDTH  row count; the top connects it to `scytale_key[15:8]`.
- `key_M`  in  KEY_WIDTH  column count; the top connects it to `scytale_key[7:0]`.
- `busy`  out  1  engine is emitting; upstream must hold `valid_i` low.
- `data_o`  out  D_WIDTH  plaintext character (registered).
- `valid_o`  out  1  `data_o` is valid this cycle.

## Operation
- States: COLLECT (reset state) and EMIT.
- **COLLECT:**
  - On `valid_i` with `data_i != START_DECRYPTION_TOKEN`, store the byte at `buf[cnt]` and increment `cnt`.
  - On `valid_i` with the token, latch `L = cnt`, latch `key_N` and `key_M`, and set `j = 0`, `k = 0`.
  - If `L == 0`, stay in COLLECT. Otherwise go to EMIT.
- **EMIT:**
  - Each cycle, output `buf[j]` and increment `k`.
  - Next `j = j + M` if `j + M < L`. Otherwise next `j = j + M - L + 1`.
  - When `k == L - 1`, the last byte is output; clear `cnt` and go to COLLECT.
- Example, M=3: buffer "ABCDEF" emits "ADBECF".
- The latched keys are used for the whole message; key changes during EMIT have no effect.
- `valid_i` during EMIT is ignored and the byte is dropped.
- Overflow: with `cnt == MAX_NOF_CHARS`, further non-token bytes are dropped. The token is still accepted.
- Index arithmetic uses an internal `$clog2(MAX_NOF_CHARS)+1`-bit width. `j + M` is computed without truncation.
- `key_M == 0` is treated as 1.

## Timing
- Reset values:
  - outputs: `busy=0`, `valid_o=0`, `data_o=0`;
  - internal: state COLLECT, `cnt=0`.
- First `valid_o` occurs one cycle after the token cycle. Bytes are then back-to-back for L cycles, with no gaps.
- `busy` is high from the cycle after the token through the cycle of the last `valid_o`. It is low the following cycle, when the next byte may be accepted.
- The `valid_o` pattern for a message is exactly L consecutive cycles.
- `data_o` holds its last value while `valid_o=0`.
- Reset mid-EMIT: outputs clear immediately (asynchronously) and the buffered message is discarded.

## Configuration
- `SCYTALE_KEY_CHECK_EN`:
  - **Defined:** at the token, if `L != key_N*key_M` or overflow occurred, the engine enters neither EMIT nor busy. It pulses the `err_o` output (1 bit, reset 0) high for one cycle, the cycle after the token, clears `cnt` and stays in COLLECT.
  - **Undefined:** `err_o` does not exist, and any L > 0 is decrypted using `key_M` alone. This includes the reset key 16'hFFFF, treated as M=255: the output equals the input order whenever M ≥ L.

## Structure
- Shared package `decryption_pkg`: `D_WIDTH`, `KEY_WIDTH`, `MAX_NOF_CHARS`, `START_DECRYPTION_TOKEN`, state enum `scy_state_t` {COLLECT, EMIT}.
- One sub-module, `scytale_char_buffer`, a MAX_NOF_CHARS×D_WIDTH register array:
  - one synchronous write port;
  - one combinational read port;
  - its write pointer is owned by the parent.

## Test plan
- N=2, M=3: feed "ABCDEF" then 8'hFA → `valid_o` for 6 consecutive cycles starting the cycle after the token, `data_o`="ADBECF", `busy` high for exactly those 6 cycles.
- N=3, M=2: "ABCDEF"+FA → "ACEBDF"; then "XY"+FA with N=1, M=2 → "XY". This checks back-to-back messages after `busy` falls.
- Token as the first byte → no `valid_o`, `busy` stays 0.
- Change `key_M` from 3 to 2 during EMIT of "ABCDEF" → output still "ADBECF"; bytes driven on `valid_i` during EMIT do not appear in the next message.
- Assert `rst_n=0` at the third EMIT cycle → `valid_o`, `busy` and `data_o` go 0 without waiting for a clock edge. The next "ABCDEF"+FA decrypts correctly.
- With `SCYTALE_KEY_CHECK_EN`: N=2, M=3, feed "ABCDE"+FA → `err_o` pulses 1 cycle, no `valid_o`. Feeding 52 bytes + FA → `err_o` pulse.
